alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Shares one combinational 16-bit ALU among N requesters.
- Round-robin arbitration over valid/ready request channels; issues one operation at a time through registered ALU drive ports.
- Captures the ALU result and flags, returns them on a single shared response channel tagged with the requester id.
- Keeps one carry/borrow flag per requester so multi-word add/sub chains from different requesters stay independent.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, requester id width; must equal clog2(N).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N  per-requester request valid.
- req_ready  out  N  per-requester accept; one-hot or zero.
- req_op1  in  16*N  operand 1; requester i occupies bits [16i+15:16i].
- req_op2  in  16*N  operand 2; same packing as req_op1.
- req_sel  in  4*N  ALU opcode; requester i occupies bits [4i+3:4i].
- req_chain  in  N  1 = drive carry_in from this requester's stored carry flag; 0 = drive carry_in = 0.
- clr_carry  in  N  synchronous clear of a requester's stored carry flag.
- alu_op1  out  16  to ALU op1.
- alu_op2  out  16  to ALU op2.
- alu_sel  out  4  to ALU sel.
- alu_carry_in  out  1  to ALU carry_in.
- alu_out  in  17  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_neg  in  1  ALU negative flag.
- alu_overflow  in  1  ALU overflow flag.
- alu_parity  in  1  ALU parity flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  id of the requester that issued the operation.
- rsp_data  out  17  captured alu_out.
- rsp_flags  out  5  {carry, zero, neg, overflow, parity}.
- busy  out  1  high in EXEC or RESP.
- carry_flags  out  N  stored per-requester carry flags.

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; rr_ptr = N-1, so requester 0 has first priority.
  - All carry flags 0.
  - All outputs 0, including the alu_* drive registers.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid, choose g = first set bit searching upward from rr_ptr+1, modulo N.
  - Assert req_ready[g] combinationally in the same cycle.
  - On the clock edge: latch op1, op2 and sel into alu_* registers; alu_carry_in = req_chain[g] ? carry_flags[g] : 0; latch g; rr_ptr := g; go to EXEC.
  - req_ready is never asserted outside IDLE.
- EXEC (exactly one cycle, since the ALU is combinational):
  - At the edge, capture rsp_data = alu_out and rsp_id = g.
  - Capture rsp_flags = {alu_out[16], alu_zero, alu_neg, alu_overflow, alu_parity}.
  - If sel is 0000..0011, carry_flags[g] := alu_out[16]; for all other opcodes the flag is unchanged.
  - Go to RESP.
- RESP:
  - rsp_valid = 1; rsp_* held stable until rsp_ready.
  - On handshake go to IDLE. The next grant can occur in the following cycle.
  - Throughput is one operation per 3 cycles minimum; latency from request handshake to rsp_valid is 2 cycles.
- alu_* registers hold their last value outside EXEC (no toggling when idle).
- clr_carry[i] applies in any state. If it coincides with an EXEC update of the same flag, the clear wins.
- Requester rule: once req_valid is high, it must hold with stable payload until req_ready. The controller samples only on handshake; dropping valid before grant is tolerated and simply removes that requester from arbitration.
- Arbitration is round-robin. No requester waits more than N-1 grants while its valid is held.
- rsp_ready held low: the FSM stalls in RESP indefinitely; no new grants.
- Reset mid-operation: the in-flight operation is discarded, no response is produced, and carry flags are cleared.
- rsp_flags carry bit is alu_out[16] for every opcode. Only the stored flag update is opcode-gated.

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD=0000, OP_ADC=0001, OP_SUB=0010, OP_SBC=0011 … OP_LSR=1111;
  - state encoding IDLE/EXEC/RESP;
  - flag bit indices FLG_C=4, FLG_Z=3, FLG_N=2, FLG_V=1, FLG_P=0.
- One natural sub-module: rr_pick. It is a combinational round-robin picker with inputs req[N] and ptr, and outputs a one-hot grant plus an encoded id. It is reusable by other shared-resource controllers.

Test Plan:
- Reset, then requester 0 issues sel 0000 with op1 0x1234, op2 0x0001 → req_ready[0] in the issue cycle; rsp_valid 2 cycles later; rsp_data 0x01235, rsp_id 0, rsp_flags carry=0 zero=0.
- Requester 1 issues sel 0001, op1 0xFFFF, op2 0x0001, chain 0 → rsp_data 0x10000, rsp_flags C=1 Z=0, carry_flags[1]=1. Then sel 0001, 0x0000+0x0000, chain 1 → alu_carry_in 1, rsp_data 0x00001, carry_flags[1]=0.
- All four req_valid held high from reset, rsp_ready=1 → grant order 0,1,2,3,0; one grant every 3 cycles.
- rsp_ready low for 5 cycles during RESP → rsp_valid and rsp_data stable; req_ready stays 0 on all requesters; the grant occurs the cycle after handshake.
- Requester 2 sets its carry via sel 0000, 0x8000+0x8000, and asserts clr_carry[2] in that EXEC cycle → carry_flags[2]=0 while rsp_flags C=1.
- rst_n pulsed low during EXEC → no rsp_valid, all outputs 0, carry_flags 0. The next grant goes to requester 0 if valid.

Source files
------------

// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: FSM encoding, opcode
// map, response flag layout and the carry-update opcode predicate.
package alu_share_ctrl_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Datapath widths
    localparam int unsigned DW = 16;  // operand width
    localparam int unsigned RW = 17;  // result width (carry/borrow in the MSB)
    localparam int unsigned SW = 4;   // opcode width
    localparam int unsigned FW = 5;   // response flag width

    // ALU opcode map
    localparam logic [SW-1:0] OP_ADD  = 4'b0000;
    localparam logic [SW-1:0] OP_ADC  = 4'b0001;
    localparam logic [SW-1:0] OP_SUB  = 4'b0010;
    localparam logic [SW-1:0] OP_SBC  = 4'b0011;
    localparam logic [SW-1:0] OP_AND  = 4'b0100;
    localparam logic [SW-1:0] OP_OR   = 4'b0101;
    localparam logic [SW-1:0] OP_XOR  = 4'b0110;
    localparam logic [SW-1:0] OP_NOT  = 4'b0111;
    localparam logic [SW-1:0] OP_INC  = 4'b1000;
    localparam logic [SW-1:0] OP_DEC  = 4'b1001;
    localparam logic [SW-1:0] OP_PASA = 4'b1010;
    localparam logic [SW-1:0] OP_PASB = 4'b1011;
    localparam logic [SW-1:0] OP_LSL  = 4'b1100;
    localparam logic [SW-1:0] OP_ROL  = 4'b1101;
    localparam logic [SW-1:0] OP_ASR  = 4'b1110;
    localparam logic [SW-1:0] OP_LSR  = 4'b1111;

    // Bit positions inside rsp_flags
    localparam int unsigned FLG_C = 4;
    localparam int unsigned FLG_Z = 3;
    localparam int unsigned FLG_N = 2;
    localparam int unsigned FLG_V = 1;
    localparam int unsigned FLG_P = 0;

    // Operation latched into the ALU drive registers on a grant
    typedef struct packed {
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [SW-1:0] sel;
        logic          cin;
    } alu_cmd_t;

    // Only the add/sub family writes a requester's stored carry flag
    function automatic logic op_updates_carry(input logic [SW-1:0] sel);
        return (sel >= OP_ADD) && (sel <= OP_SBC);
    endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_pick.sv
// Combinational round-robin picker. Searches upward from ptr+1 (wrapping
// modulo N) and returns the first requesting index as one-hot and encoded.
module alu_share_ctrl_rr_pick #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] id,
    output logic           found
);

    logic [IDW-1:0] idx;

    // Rotating priority search; the first hit past ptr wins
    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = IDW'((32'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                id         = idx;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational 16-bit ALU among N requesters. Round-robin grant
// in IDLE, one cycle of execution, then the result is held on a single
// response channel until accepted. A carry flag per requester keeps
// multi-word add/sub chains from different requesters independent.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [DW*N-1:0]   req_op1,
    input  logic [DW*N-1:0]   req_op2,
    input  logic [SW*N-1:0]   req_sel,
    input  logic [N-1:0]      req_chain,
    input  logic [N-1:0]      clr_carry,

    output logic [DW-1:0]     alu_op1,
    output logic [DW-1:0]     alu_op2,
    output logic [SW-1:0]     alu_sel,
    output logic              alu_carry_in,
    input  logic [RW-1:0]     alu_out,
    input  logic              alu_zero,
    input  logic              alu_neg,
    input  logic              alu_overflow,
    input  logic              alu_parity,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [RW-1:0]     rsp_data,
    output logic [FW-1:0]     rsp_flags,

    output logic              busy,
    output logic [N-1:0]      carry_flags
);

    state_e         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] cur_id;

    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           grant_found;

    alu_cmd_t       pick_cmd;
    logic [FW-1:0]  exec_flags;

    alu_share_ctrl_rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .id    (grant_id),
        .found (grant_found)
    );

    // Accept is offered only while idle; held low throughout reset so every
    // output reads zero while rst_n is asserted
    always_comb begin
        req_ready = '0;
        if (rst_n && (state == IDLE)) begin
            req_ready = grant;
        end
    end

    // Select the granted requester's payload; chained ops pull its own carry
    always_comb begin
        pick_cmd = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                pick_cmd.op1 = req_op1[DW*i +: DW];
                pick_cmd.op2 = req_op2[DW*i +: DW];
                pick_cmd.sel = req_sel[SW*i +: SW];
                pick_cmd.cin = req_chain[i] & carry_flags[i];
            end
        end
    end

    // Pack ALU status into the response flag layout; carry reported for all ops
    always_comb begin
        exec_flags        = '0;
        exec_flags[FLG_C] = alu_out[RW-1];
        exec_flags[FLG_Z] = alu_zero;
        exec_flags[FLG_N] = alu_neg;
        exec_flags[FLG_V] = alu_overflow;
        exec_flags[FLG_P] = alu_parity;
    end

    // Control FSM with registered ALU drive and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= IDW'(N - 1);
            cur_id       <= '0;
            alu_op1      <= '0;
            alu_op2      <= '0;
            alu_sel      <= '0;
            alu_carry_in <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_data     <= '0;
            rsp_flags    <= '0;
            busy         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_found) begin
                        alu_op1      <= pick_cmd.op1;
                        alu_op2      <= pick_cmd.op2;
                        alu_sel      <= pick_cmd.sel;
                        alu_carry_in <= pick_cmd.cin;
                        cur_id       <= grant_id;
                        rr_ptr       <= grant_id;
                        busy         <= 1'b1;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU is combinational: its result is settled by this edge
                    rsp_data  <= alu_out;
                    rsp_id    <= cur_id;
                    rsp_flags <= exec_flags;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Per-requester carry storage; an explicit clear beats an EXEC update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_flags <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (clr_carry[i]) begin
                    carry_flags[i] <= 1'b0;
                end else if ((state == EXEC) && (cur_id == IDW'(i)) &&
                             op_updates_carry(alu_sel)) begin
                    carry_flags[i] <= alu_out[RW-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: a behavioural ALU drives the ALU return ports,
// a transaction-level model tracks grants, responses and carry flags, and
// directed cases plus a randomized phase exercise the controller.
module tb_alu_share_ctrl;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [16*N-1:0]   req_op1;
    logic [16*N-1:0]   req_op2;
    logic [4*N-1:0]    req_sel;
    logic [N-1:0]      req_chain;
    logic [N-1:0]      clr_carry;
    logic [15:0]       alu_op1;
    logic [15:0]       alu_op2;
    logic [3:0]        alu_sel;
    logic              alu_carry_in;
    logic [16:0]       alu_out;
    logic              alu_zero;
    logic              alu_neg;
    logic              alu_overflow;
    logic              alu_parity;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [16:0]       rsp_data;
    logic [4:0]        rsp_flags;
    logic              busy;
    logic [N-1:0]      carry_flags;

    logic [15:0] t_op1 [N];
    logic [15:0] t_op2 [N];
    logic [3:0]  t_sel [N];

    int total = 0;
    int bad   = 0;

    alu_share_ctrl #(
        .N   (N),
        .IDW (IDW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op1      (req_op1),
        .req_op2      (req_op2),
        .req_sel      (req_sel),
        .req_chain    (req_chain),
        .clr_carry    (clr_carry),
        .alu_op1      (alu_op1),
        .alu_op2      (alu_op2),
        .alu_sel      (alu_sel),
        .alu_carry_in (alu_carry_in),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .alu_neg      (alu_neg),
        .alu_overflow (alu_overflow),
        .alu_parity   (alu_parity),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_flags    (rsp_flags),
        .busy         (busy),
        .carry_flags  (carry_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural ALU: returns {result[16:0], zero, neg, overflow, parity}
    function automatic logic [20:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [3:0] s, input logic c);
        logic [16:0] r;
        logic        v;
        v = 1'b0;
        case (s)
            4'd0:    r = {1'b0, a} + {1'b0, b};
            4'd1:    r = {1'b0, a} + {1'b0, b} + {16'd0, c};
            4'd2:    r = {1'b0, a} - {1'b0, b};
            4'd3:    r = {1'b0, a} - {1'b0, b} - {16'd0, c};
            4'd4:    r = {1'b0, a & b};
            4'd5:    r = {1'b0, a | b};
            4'd6:    r = {1'b0, a ^ b};
            4'd7:    r = {1'b0, ~a};
            4'd8:    r = {1'b0, a} + 17'd1;
            4'd9:    r = {1'b0, a} - 17'd1;
            4'd10:   r = {1'b0, a};
            4'd11:   r = {1'b0, b};
            4'd12:   r = {a, 1'b0};
            4'd13:   r = {a[15], a[14:0], a[15]};
            4'd14:   r = {a[0], a[15], a[15:1]};
            default: r = {a[0], 1'b0, a[15:1]};
        endcase
        if (s <= 4'd1) v = (a[15] == b[15]) && (r[15] != a[15]);
        else if (s <= 4'd3) v = (a[15] != b[15]) && (r[15] != a[15]);
        return {r, (r == 17'd0), r[15], v, ^r[15:0]};
    endfunction

    logic [20:0] alu_vec;
    always_comb begin
        alu_vec      = alu_model(alu_op1, alu_op2, alu_sel, alu_carry_in);
        alu_out      = alu_vec[20:4];
        alu_zero     = alu_vec[3];
        alu_neg      = alu_vec[2];
        alu_overflow = alu_vec[1];
        alu_parity   = alu_vec[0];
    end

    always_comb begin
        req_op1 = '0;
        req_op2 = '0;
        req_sel = '0;
        for (int i = 0; i < N; i++) begin
            req_op1[16*i +: 16] = t_op1[i];
            req_op2[16*i +: 16] = t_op2[i];
            req_sel[4*i +: 4]   = t_sel[i];
        end
    end

    // Round-robin rule: first valid index after the last grant, wrapping
    function automatic int rr_next(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Transaction-level reference model
    bit          m_busy;
    int          m_age;
    int          m_id;
    int          m_last;
    logic [N-1:0] m_carry;
    logic [15:0] m_a1, m_a2;
    logic [3:0]  m_sel;
    logic        m_cin;
    logic [16:0] m_res;
    logic [4:0]  m_flags;
    logic [N-1:0] exp_ready;
    logic [20:0] m_vec;
    int          g;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_age   = 0;
            m_last  = N - 1;
            m_carry = '0;
            m_a1    = '0;
            m_a2    = '0;
            m_sel   = '0;
            m_cin   = 1'b0;
            check("rst_alu", {alu_op1, alu_op2, alu_sel, alu_carry_in}, 64'd0);
            check("rst_rsp", {rsp_valid, rsp_id, rsp_data, rsp_flags, busy, carry_flags,
                              req_ready}, 64'd0);
        end else begin
            exp_ready = '0;
            g = -1;
            if (!m_busy) begin
                g = rr_next(req_valid, m_last);
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            check("req_ready", req_ready, exp_ready);
            check("rsp_valid", rsp_valid, m_busy && (m_age >= 2));
            check("busy", busy, m_busy);
            check("alu_drive", {alu_op1, alu_op2, alu_sel, alu_carry_in},
                  {m_a1, m_a2, m_sel, m_cin});
            check("carry_flags", carry_flags, m_carry);
            if (m_busy && (m_age >= 2)) begin
                check("rsp_id", rsp_id, m_id);
                check("rsp_data", rsp_data, m_res);
                check("rsp_flags", rsp_flags, m_flags);
            end
            if (m_busy && (m_age == 1) && (m_sel <= 4'd3)) m_carry[m_id] = m_res[16];
            if (m_busy && (m_age >= 2) && rsp_ready) m_busy = 1'b0;
            else if (m_busy) m_age++;
            if (g >= 0) begin
                m_id    = g;
                m_a1    = t_op1[g];
                m_a2    = t_op2[g];
                m_sel   = t_sel[g];
                m_cin   = req_chain[g] & m_carry[g];
                m_vec   = alu_model(m_a1, m_a2, m_sel, m_cin);
                m_res   = m_vec[20:4];
                m_flags = {m_vec[20], m_vec[3:0]};
                m_busy  = 1'b1;
                m_age   = 1;
                m_last  = g;
            end
            m_carry = m_carry & ~clr_carry;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Present one request, wait (bounded) for its grant, drop valid in EXEC
    task automatic issue(input int i, input logic [3:0] s, input logic [15:0] a,
                         input logic [15:0] b, input logic ch);
        bit ok;
        t_op1[i] = a;
        t_op2[i] = b;
        t_sel[i] = s;
        req_chain[i] = ch;
        req_valid[i] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
        check("grant_wait", ok, 1'b1);
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
    endtask

    task automatic rand_payload(input int i);
        t_op1[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        t_op2[i] = 16'($urandom);
        t_sel[i] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
        req_chain[i] = 1'($urandom);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int gseq[$];
        int gcyc[$];
        logic [N-1:0] hs;

        rst_n     = 1'b0;
        req_valid = '0;
        req_chain = '0;
        clr_carry = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            t_op1[i] = '0;
            t_op2[i] = '0;
            t_sel[i] = '0;
        end
        do_reset();

        // Plain add from requester 0, latency 2
        issue(0, 4'd0, 16'h1234, 16'h0001, 1'b0);
        @(negedge clk);
        check("t1_exec_valid", rsp_valid, 1'b0);
        @(negedge clk);
        check("t1_rsp_valid", rsp_valid, 1'b1);
        check("t1_rsp_data", rsp_data, 17'h01235);
        check("t1_rsp_id", rsp_id, 2'd0);
        check("t1_flag_cz", rsp_flags[4:3], 2'b00);
        @(posedge clk); #1;

        // Carry generation then chained consumption on requester 1
        issue(1, 4'd1, 16'hFFFF, 16'h0001, 1'b0);
        @(negedge clk);
        check("t2_cin0", alu_carry_in, 1'b0);
        @(negedge clk);
        check("t2_data_a", rsp_data, 17'h10000);
        check("t2_flag_cz", rsp_flags[4:3], 2'b10);
        check("t2_carry1_set", carry_flags[1], 1'b1);
        @(posedge clk); #1;
        issue(1, 4'd1, 16'h0000, 16'h0000, 1'b1);
        @(negedge clk);
        check("t2_cin1", alu_carry_in, 1'b1);
        @(negedge clk);
        check("t2_data_b", rsp_data, 17'h00001);
        check("t2_carry1_clr", carry_flags[1], 1'b0);
        @(posedge clk); #1;

        // All requesters valid from reset: grants 0,1,2,3,0 three cycles apart
        for (int i = 0; i < N; i++) begin
            t_op1[i] = 16'(i * 16'h0111);
            t_op2[i] = 16'h0003;
            t_sel[i] = 4'd0;
        end
        req_chain = '0;
        req_valid = '1;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    gseq.push_back(i);
                    gcyc.push_back(c);
                end
            end
        end
        check("t3_grant_count", (gseq.size() >= 5), 1'b1);
        for (int k = 0; k < 5; k++) begin
            if (k < gseq.size()) begin
                check("t3_grant_order", gseq[k], k % N);
                check("t3_grant_cycle", gcyc[k], 3 * k);
            end
        end
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk);
        #1;

        // Response stall: outputs hold, no grants, grant right after handshake
        rsp_ready = 1'b0;
        issue(3, 4'd2, 16'h0005, 16'h0007, 1'b0);
        t_op1[0] = 16'h0042;
        t_op2[0] = 16'h0001;
        t_sel[0] = 4'd6;
        req_valid[0] = 1'b1;
        @(negedge clk);
        repeat (6) begin
            @(negedge clk);
            check("t4_hold_valid", rsp_valid, 1'b1);
            check("t4_hold_data", rsp_data, 17'h1FFFE);
            check("t4_no_ready", req_ready, 4'b0000);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("t4_hs_valid", rsp_valid, 1'b1);
        check("t4_hs_no_ready", req_ready, 4'b0000);
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_regrant", req_ready, 4'b0001);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Clear coinciding with a carry-setting EXEC: clear wins
        issue(2, 4'd0, 16'h8000, 16'h8000, 1'b0);
        clr_carry[2] = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 clr_carry[2] = 1'b0;
        @(negedge clk);
        check("t5_carry2", carry_flags[2], 1'b0);
        check("t5_flag_c", rsp_flags[4], 1'b1);
        check("t5_data", rsp_data, 17'h10000);
        @(posedge clk); #1;

        // Randomized traffic with random back-pressure and clears
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    req_valid[i] = 1'($urandom);
                    rand_payload(i);
                end else if (!req_valid[i] && ($urandom_range(0, 3) == 0)) begin
                    rand_payload(i);
                    req_valid[i] = 1'b1;
                end
                clr_carry[i] = ($urandom_range(0, 15) == 0);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0;
        clr_carry = '0;
        rsp_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Reset during EXEC discards the operation and clears carries
        issue(3, 4'd0, 16'hFFFF, 16'h0001, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("t6_carry3_pre", carry_flags[3], 1'b1);
        issue(1, 4'd0, 16'h1111, 16'h2222, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_alu", {alu_op1, alu_op2, alu_sel, alu_carry_in}, 64'd0);
        check("t6_rst_rsp", {rsp_valid, rsp_id, rsp_data, rsp_flags, busy, carry_flags,
                             req_ready}, 64'd0);
        t_op1[0] = 16'h0010;
        t_op2[0] = 16'h0020;
        t_sel[0] = 4'd0;
        req_chain[0] = 1'b0;
        t_op1[1] = 16'h0030;
        req_valid[0] = 1'b1;
        req_valid[1] = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("t6_grant0", req_ready, 4'b0001);
        check("t6_no_rsp", rsp_valid, 1'b0);
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
